// File: rtl/emulib_burst_arbiter.sv
// emulib_burst_arbiter: round-robin arbiter that merges NUM_REQ requester
// streams into one registered output stage (m_valid/m_data/m_last/m_id).
// Optional build macro EMULIB_ARB_BURST_LOCK_EN: when defined, a grant is
// held from the first beat of a burst until its s_last beat (state LOCKED).
// When undefined, every beat is arbitrated on its own and busy stays 0.
module emulib_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       s_valid,
  output logic [NUM_REQ-1:0]       s_ready,
  input  logic [NUM_REQ*WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]       s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_last,
  output logic [IDW-1:0]           m_id,
  output logic                     busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [IDW-1:0] ptr_r, ptr_nxt_s;
  logic [IDW-1:0] grant_r, grant_nxt_s;
  logic [IDW-1:0] win_idx_s;
  logic           win_found_s;
  logic           can_load_s;
  logic           accept_s;

  // Index after idx, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      return '0;
    end else begin
      return idx + IDW'(1);
    end
  endfunction

  // The output register can take a new beat when empty or draining this cycle.
  assign can_load_s = !m_valid || m_ready;
  assign accept_s   = can_load_s && win_found_s;
  assign busy       = (state_r == LOCKED);

  // Winner select: granted requester while locked, else round-robin from ptr.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    if (state_r == LOCKED) begin
      win_found_s = s_valid[grant_r];
      win_idx_s   = grant_r;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_found_s && s_valid[(int'(ptr_r) + k) % NUM_REQ]) begin
          win_found_s = 1'b1;
          win_idx_s   = IDW'((int'(ptr_r) + k) % NUM_REQ);
        end else begin
          win_found_s = win_found_s;
        end
      end
    end
  end

  // Only the winner sees ready, and only while reset is released.
  always_comb begin
    s_ready = '0;
    if (accept_s && rst_n) begin
      s_ready[win_idx_s] = 1'b1;
    end else begin
      s_ready = '0;
    end
  end

  // Next-state: lock/unlock on burst boundaries and advance the rotation pointer.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    grant_nxt_s = grant_r;
    if (accept_s) begin
`ifdef EMULIB_ARB_BURST_LOCK_EN
      if (s_last[win_idx_s]) begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = wrap_inc(win_idx_s);
      end else begin
        state_nxt_s = LOCKED;
        grant_nxt_s = win_idx_s;
      end
`else
      state_nxt_s = IDLE;
      ptr_nxt_s   = wrap_inc(win_idx_s);
`endif
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Arbitration state registers; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      grant_r <= grant_nxt_s;
    end
  end

  // Output stage: load on acceptance, otherwise empty once the beat drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (accept_s) begin
      m_valid <= 1'b1;
      m_data  <= s_data[win_idx_s*WIDTH +: WIDTH];
      m_last  <= s_last[win_idx_s];
      m_id    <= win_idx_s;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= m_valid;
    end
  end

endmodule

// File: tb/tb_emulib_burst_arbiter.sv
// Testbench for emulib_burst_arbiter: directed phases with a beat scoreboard
// and per-phase expected m_id / m_last orderings.
module tb_emulib_burst_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     s_valid = '0;
  logic [N-1:0]     s_ready;
  logic [N*W-1:0]   s_data = '0;
  logic [N-1:0]     s_last = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [W-1:0]     m_data;
  logic             m_last;
  logic [IDW-1:0]   m_id;
  logic             busy;

  always #5 clk = ~clk;

  emulib_burst_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_id(m_id), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Requester beat sources
  logic [W-1:0] dbuf [N][DEPTH];
  logic         lbuf [N][DEPTH];
  int           hd [N];
  int           tl [N];
  int           seqn = 0;

  // Reference model state
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           last;
  } beat_t;
  beat_t          sbq[$];
  logic           mv = 1'b0;
  logic           mlock = 1'b0;
  logic [IDW-1:0] mptr = '0;
  logic [IDW-1:0] mgrant = '0;
  int             idseq;
  int             lastseq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_burst(input int i, input int len);
    for (int b = 0; b < len; b++) begin
      dbuf[i][tl[i]] = {8'(i), 24'(seqn)};
      lbuf[i][tl[i]] = (b == len - 1);
      seqn++;
      tl[i]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid[i]       = (hd[i] < tl[i]);
      s_last[i]        = (hd[i] < tl[i]) ? lbuf[i][hd[i]] : 1'b0;
      s_data[i*W +: W] = (hd[i] < tl[i]) ? dbuf[i][hd[i]] : '0;
    end
  endtask

  function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + IDW'(1);
  endfunction

  // One clock: drive at negedge, check #1 later, update model at posedge.
  task automatic step(input logic mr);
    logic           found;
    logic [IDW-1:0] win;
    logic           acc;
    logic [N-1:0]   exp_rdy;
    beat_t          nb;
    drive();
    m_ready = mr;
    #1;
    found = 1'b0;
    win   = '0;
    if (mlock) begin
      found = s_valid[mgrant];
      win   = mgrant;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && s_valid[(int'(mptr) + k) % N]) begin
          found = 1'b1;
          win   = IDW'((int'(mptr) + k) % N);
        end
      end
    end
    acc     = (!mv || mr) && found;
    exp_rdy = acc ? (N'(1) << win) : '0;
    chk("s_ready", 64'(s_ready), 64'(exp_rdy));
    chk("m_valid", 64'(m_valid), 64'(mv));
    chk("busy", 64'(busy), 64'(mlock));
    if (mv) begin
      chk("m_id", 64'(m_id), 64'(sbq[0].id));
      chk("m_data", 64'(m_data), 64'(sbq[0].data));
      chk("m_last", 64'(m_last), 64'(sbq[0].last));
    end
    if (m_valid && mr) begin
      idseq   = idseq * 16 + int'(m_id) + 1;
      lastseq = lastseq * 16 + int'(m_last) + 1;
    end
    @(posedge clk);
    if (mv && mr) void'(sbq.pop_front());
    if (acc) begin
      nb.id   = win;
      nb.data = dbuf[win][hd[win]];
      nb.last = lbuf[win][hd[win]];
      sbq.push_back(nb);
      mv = 1'b1;
      hd[win]++;
`ifdef EMULIB_ARB_BURST_LOCK_EN
      if (nb.last) begin
        mlock = 1'b0;
        mptr  = inc(win);
      end else begin
        mlock  = 1'b1;
        mgrant = win;
      end
`else
      mptr = inc(win);
`endif
    end else if (mr) begin
      mv = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step(1'b1);
  endtask

  function automatic bit pending();
    bit p = mv;
    for (int i = 0; i < N; i++) if (hd[i] < tl[i]) p = 1'b1;
    return p;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    // Reset state, with requesters asserting valid during reset
    s_valid = 4'b1111;
    #3;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_id", 64'(m_id), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    s_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // 3-beat burst from req0
    idseq = 0; lastseq = 0;
    add_burst(0, 3);
    run(5);
    chk("burst3_ids", 64'(idseq), 64'h111);
    chk("burst3_lasts", 64'(lastseq), 64'h112);

    // Pointer sits at 1 after req0: req1 wins over req0
    idseq = 0;
    add_burst(0, 1); add_burst(1, 1);
    run(4);
    chk("ptr_after_req0", 64'(idseq), 64'h21);

    idseq = 0;
    add_burst(1, 1); add_burst(2, 1); add_burst(3, 1);
    run(5);
    chk("rotate_123", 64'(idseq), 64'h234);

    // All four single-beat, req0 twice: 0,1,2,3,0
    idseq = 0;
    add_burst(0, 1); add_burst(0, 1); add_burst(1, 1); add_burst(2, 1); add_burst(3, 1);
    run(7);
    chk("rr_singles", 64'(idseq), 64'h12341);

    // req0 mid-burst, req2 waiting, downstream stalled for 5 cycles
    idseq = 0;
    add_burst(0, 3);
    step(1'b1);
    add_burst(2, 1);
    for (int c = 0; c < 5; c++) step(1'b0);
    run(5);
`ifdef EMULIB_ARB_BURST_LOCK_EN
    chk("stall_ids", 64'(idseq), 64'h1113);
`else
    chk("stall_ids", 64'(idseq), 64'h1311);
`endif

    // Reset pulsed after 2 of 4 beats of a req1 burst
    add_burst(1, 4);
    run(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_m_last", 64'(m_last), 64'd0);
    mv = 1'b0; mlock = 1'b0; mptr = '0; mgrant = '0;
    sbq.delete();
    hd[1] = tl[1];
    @(negedge clk);
    rst_n = 1'b1;
    idseq = 0;
    add_burst(3, 1); add_burst(2, 1);
    run(4);
    chk("after_rst_ids", 64'(idseq), 64'h34);

    // req0 and req1 each a 2-beat burst
    idseq = 0; lastseq = 0;
    add_burst(0, 2); add_burst(1, 2);
    run(6);
`ifdef EMULIB_ARB_BURST_LOCK_EN
    chk("two_bursts_ids", 64'(idseq), 64'h1122);
    chk("two_bursts_lasts", 64'(lastseq), 64'h1212);
`else
    chk("two_bursts_ids", 64'(idseq), 64'h1212);
    chk("two_bursts_lasts", 64'(lastseq), 64'h1122);
`endif

    // Mixed bursts with random backpressure, then bounded drain
    for (int i = 0; i < N; i++) begin
      add_burst(i, 1 + (i % 3));
      add_burst(i, 2);
    end
    for (int c = 0; c < 40; c++) step(1'(($urandom_range(0, 1))));
    for (int c = 0; c < 40 && pending(); c++) step(1'b1);
    chk("drain_done", 64'(pending()), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emulib_burst_arbiter.md
EMULIB_BURST_ARBITER -- requirements
Module: emulib_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester streams (2..16).
REQ-002 SHALL have parameter WIDTH, default 32, data width per beat.
REQ-003 SHALL have parameter IDW, default $clog2(NUM_REQ), requester index width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port s_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port s_ready  output  NUM_REQ  per-requester beat accepted.
REQ-008 SHALL have port s_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port s_last  input  NUM_REQ  per-requester last beat of burst.
REQ-010 SHALL have port m_valid  output  1  downstream beat valid (feeds a FIFO write side).
REQ-011 SHALL have port m_ready  input  1  downstream ready (FIFO iready).
REQ-012 SHALL have port m_data  output  WIDTH  downstream data.
REQ-013 SHALL have port m_last  output  1  downstream last flag.
REQ-014 SHALL have port m_id  output  IDW  index of requester that sourced the current m_data.
REQ-015 SHALL have port busy  output  1  high while state is LOCKED.

Function
REQ-016 SHALL hold m_valid/m_data/m_last/m_id in one output register; the register loads when (!m_valid || m_ready) and a requester is accepted.
REQ-017 SHALL implement states IDLE and LOCKED.
REQ-018 SHALL, in IDLE, pick the winner combinationally by round-robin: the first asserted s_valid at or after index ptr, wrapping from NUM_REQ-1 to 0.
REQ-019 SHALL assert s_ready only for the winner/granted index, and only when the output register can load; every other s_ready bit SHALL be 0.
REQ-020 SHALL present an accepted beat on m_* exactly 1 cycle after the s_valid&&s_ready cycle.
REQ-021 SHALL move IDLE->LOCKED when an accepted beat has s_last=0, latching grant=winner.
REQ-022 SHALL stay in IDLE when an accepted beat has s_last=1 (single-beat burst) and set ptr=winner+1 (wrap).
REQ-023 SHALL, in LOCKED, accept only the granted requester, ignoring all other s_valid.
REQ-024 SHALL move LOCKED->IDLE on acceptance of a granted beat with s_last=1 and set ptr=grant+1 (wrap).
REQ-025 SHALL accept a new beat in the same cycle the previous one drains (m_valid&&m_ready), giving 1 beat/cycle throughput.
REQ-026 SHALL hold m_* stable while m_valid=1 and m_ready=0.
REQ-027 SHALL, with no s_valid asserted in IDLE, leave ptr unchanged and m_valid clear after the pending beat drains.

Reset
REQ-028 SHALL, on rst_n=0 (any time, including mid-burst), immediately clear m_valid, m_last, m_data, m_id, busy, s_ready, ptr, and grant, and return to IDLE; a partially forwarded burst is abandoned.
REQ-029 SHALL resume arbitration from ptr=0 on the first edge after rst_n rises.

Configuration
REQ-030 SHALL honour macro EMULIB_ARB_BURST_LOCK_EN: when defined, behaviour is REQ-021..REQ-024 (grant held until s_last).
REQ-031 SHALL, when EMULIB_ARB_BURST_LOCK_EN is undefined, never enter LOCKED (busy=0): arbitrate each beat independently and set ptr=winner+1 after every accepted beat; m_last still passes through.

Verification
REQ-032 SHALL pass: reset, then s_valid=4'b0001 with a 3-beat burst (last on beat 3), m_ready=1 -> m_id=0 for 3 consecutive cycles starting 1 cycle after the first beat; busy=1 through beats 1-2; ptr=1 afterwards.
REQ-033 SHALL pass: all four s_valid high, single-beat bursts, m_ready=1 -> m_id sequence 0,1,2,3,0.
REQ-034 SHALL pass: req0 mid-burst with req2 valid, m_ready=0 for 5 cycles -> m_* stable, s_ready=0, req2 not granted until req0 sends last.
REQ-035 SHALL pass: rst_n pulsed low after 2 of 4 beats of a req1 burst -> m_valid=0 and busy=0 immediately; next grant goes to the lowest valid index.
REQ-036 SHALL pass: macro undefined, req0 and req1 both in 2-beat bursts -> m_id sequence 0,1,0,1 with m_last on beats 3 and 4.
